// File: rtl/syn_fifo.sv
// syn_fifo: single-clock FIFO with arbitrary depth, threshold flags, occupancy count and standard/FWFT read.
module syn_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_THR = DEPTH - 1,
  parameter int AE_THR = 1,
  parameter bit FWFT = 1'b0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  al_full,
  output logic                  al_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_THR);
  localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_THR);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  logic [CNT_W-1:0] count_nxt;
  // A write at full is only taken when the same-cycle read frees a slot.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign count_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      al_full   <= 1'b0;
      al_empty  <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count     <= count_nxt;
      full      <= count_nxt == FULL_C;
      empty     <= count_nxt == '0;
      al_full   <= count_nxt >= AF_C;
      al_empty  <= count_nxt <= AE_C;
      overflow  <= wr_en & ~wr_acc;
      underflow <= rd_en & empty;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr] <= wr_din;
  end
  if (FWFT) begin : g_fwft
    assign rd_dout  = mem[rd_ptr];
    assign rd_valid = ~empty;
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_valid <= 1'b0;
        rd_dout  <= '0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_dout <= mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_syn_fifo.sv
// tb_syn_fifo: drives a standard-mode and an FWFT-mode FIFO with identical stimulus against a queue model.
module tb_syn_fifo;
  localparam int DW = 8;
  localparam int D = 12;
  localparam int AF = 10;
  localparam int AE = 1;
  localparam int CW = $clog2(D + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [DW-1:0] wr_din = '0;
  logic [DW-1:0] s_dout, f_dout;
  logic s_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [CW-1:0] s_count, f_count;
  syn_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THR(AF), .AE_THR(AE), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_din(wr_din), .rd_en(rd_en),
    .rd_dout(s_dout), .rd_valid(s_valid), .full(s_full), .empty(s_empty),
    .al_full(s_afull), .al_empty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf));
  syn_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THR(AF), .AE_THR(AE), .FWFT(1'b1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_din(wr_din), .rd_en(rd_en),
    .rd_dout(f_dout), .rd_valid(f_valid), .full(f_full), .empty(f_empty),
    .al_full(f_afull), .al_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] q[$];
  bit m_ovf, m_udf, m_sv, chk_en;
  logic [DW-1:0] m_sd;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // Apply one cycle of inputs, then advance the model by the rules of the edge just taken.
  task automatic step(bit w, logic [DW-1:0] d, bit r, bit rs);
    bit racc, wacc;
    int n;
    wr_en = w;
    wr_din = d;
    rd_en = r;
    rst = rs;
    @(posedge clk);
    #1;
    n = q.size();
    if (rs) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      m_sv = 0;
      m_sd = '0;
    end else begin
      racc = r && n > 0;
      wacc = w && (n < D || racc);
      m_ovf = w && !wacc;
      m_udf = r && n == 0;
      m_sv = racc;
      if (racc) m_sd = q.pop_front();
      if (wacc) q.push_back(d);
    end
  endtask
  always @(negedge clk) begin
    int n;
    if (chk_en) begin
      n = q.size();
      chk("s_count", 32'(s_count), n);
      chk("f_count", 32'(f_count), n);
      chk("s_empty", 32'(s_empty), 32'(n == 0));
      chk("f_empty", 32'(f_empty), 32'(n == 0));
      chk("s_full", 32'(s_full), 32'(n == D));
      chk("f_full", 32'(f_full), 32'(n == D));
      chk("s_al_full", 32'(s_afull), 32'(n >= AF));
      chk("f_al_full", 32'(f_afull), 32'(n >= AF));
      chk("s_al_empty", 32'(s_aempty), 32'(n <= AE));
      chk("f_al_empty", 32'(f_aempty), 32'(n <= AE));
      chk("s_overflow", 32'(s_ovf), 32'(m_ovf));
      chk("f_overflow", 32'(f_ovf), 32'(m_ovf));
      chk("s_underflow", 32'(s_udf), 32'(m_udf));
      chk("f_underflow", 32'(f_udf), 32'(m_udf));
      chk("s_rd_valid", 32'(s_valid), 32'(m_sv));
      chk("s_rd_dout", 32'(s_dout), 32'(m_sd));
      chk("f_rd_valid", 32'(f_valid), 32'(n > 0));
      if (n > 0) chk("f_rd_dout", 32'(f_dout), 32'(q[0]));
    end
  end
  task automatic rand_phase(int cycles);
    int rp;
    rp = 50;
    for (int i = 0; i < cycles; i++) begin
      if (i % 40 == 0) rp = 25 + 25 * int'($urandom_range(0, 2));
      step($urandom_range(0, 99) >= rp, DW'($urandom), $urandom_range(0, 99) < rp, 1'b0);
    end
  endtask
  initial begin
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk_en = 1;
    chk("reset count", 32'(s_count), 0);
    chk("reset empty", 32'(s_empty), 1);
    chk("reset al_empty", 32'(s_aempty), 1);
    chk("reset rd_valid", 32'(s_valid), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("empty read underflow", 32'(s_udf), 1);
    chk("empty read count", 32'(f_count), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("underflow one cycle", 32'(s_udf), 0);
    for (int i = 0; i < D; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 8) chk("al_full at 9", 32'(s_afull), 0);
      if (i == 9) chk("al_full at 10", 32'(s_afull), 1);
      if (i == 10) chk("full at 11", 32'(s_full), 0);
      if (i == 11) chk("full at 12", 32'(s_full), 1);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("13th write overflow", 32'(s_ovf), 1);
    chk("13th write count", 32'(s_count), 12);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("rdwr full count", 32'(s_count), 12);
    chk("rdwr full overflow", 32'(s_ovf), 0);
    chk("rdwr full head", 32'(s_dout), 0);
    for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain last word", 32'(s_dout), 32'h A5);
    chk("drain empty", 32'(f_empty), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("std dout held", 32'(s_dout), 32'h A5);
    chk("std valid drops", 32'(s_valid), 0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("rdwr empty underflow", 32'(s_udf), 1);
    chk("rdwr empty count", 32'(s_count), 1);
    chk("rdwr empty fwft word", 32'(f_dout), 32'h5A);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("rdwr empty word read", 32'(s_dout), 32'h5A);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("fwft valid", 32'(f_valid), 1);
    chk("fwft dout", 32'(f_dout), 32'h3C);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fwft pop valid", 32'(f_valid), 0);
    rand_phase(400);
    for (int i = 0; i < 40 && q.size() != 7; i++)
      step(q.size() < 7, DW'($urandom), q.size() > 7, 1'b0);
    chk("pre-reset count", 32'(s_count), 7);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("mid reset count", 32'(s_count), 0);
    chk("mid reset full", 32'(s_full), 0);
    chk("mid reset empty", 32'(f_empty), 1);
    chk("mid reset std dout", 32'(s_dout), 0);
    chk("mid reset fwft valid", 32'(f_valid), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post reset underflow", 32'(s_udf), 1);
    chk("post reset no stale", 32'(s_valid), 0);
    rand_phase(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/syn_fifo.md
# syn_fifo

Single-clock, parametrised FIFO; successor to the team's dual-clock FIFO for paths where producer and consumer share one clock. It adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, an occupancy count, a selectable read mode (standard or first-word-fall-through), and one-cycle overflow/underflow error pulses. It sits between command/data producers and consumers inside the memory-controller clock domain.

## Interface
- DATA_WIDTH, 8, width of stored word
- DEPTH, 16, number of entries; any integer >= 2
- AF_THR, DEPTH-1, al_full asserted when count >= AF_THR; legal range 1..DEPTH
- AE_THR, 1, al_empty asserted when count <= AE_THR; legal range 0..DEPTH-1
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- CNT_W (derived), clog2(DEPTH+1), width of count
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset; one clock, sync active-high reset
- wr_en  input  1  write request
- wr_din  input  DATA_WIDTH  write data
- rd_en  input  1  read request (FWFT: pop of head word)
- rd_dout  output  DATA_WIDTH  read data
- rd_valid  output  1  rd_dout holds a valid word
- full / empty  output  1  occupancy == DEPTH / == 0
- al_full / al_empty  output  1  threshold flags
- count  output  CNT_W  current occupancy
- overflow / underflow  output  1  one-cycle error pulses

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset. wr_ptr, rd_ptr binary in 0..DEPTH-1; increment wraps DEPTH-1 -> 0 (no extra MSB; full/empty derived from count).
- wr_acc = wr_en & (~full | rd_acc); rd_acc = rd_en & ~empty.
- Write at full accepted only when a read is accepted the same cycle; count unchanged.
- Read at empty always rejected, including with simultaneous write (write accepted, count -> 1).
- count_nxt = count + wr_acc - rd_acc; never exceeds DEPTH nor goes below 0.
- full, empty, al_full, al_empty are registers loaded from count_nxt, so they are consistent with count every cycle.
- overflow = registered (wr_en & ~wr_acc); underflow = registered (rd_en & empty). Rejected operations change no pointer, count or memory.
- Standard mode (FWFT=0): on rd_acc, rd_dout <= mem[rd_ptr], rd_valid <= 1; otherwise rd_valid <= 0, rd_dout holds.
- FWFT mode (FWFT=1): rd_dout = mem[rd_ptr] (combinational from array), rd_valid = ~empty; rd_en with rd_valid pops.
- Reset (rst=1 at a clock edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, al_empty=1 (AE_THR >= 0), al_full=0, rd_valid=0, rd_dout=0 (standard mode), overflow=underflow=0. Reset mid-operation discards all content; wr_en/rd_en ignored in the reset cycle.

## Timing
- Write at edge N: count/empty/al_* update at edge N; word readable from cycle after N.
- Standard mode read latency: rd_en accepted at edge N -> rd_dout/rd_valid valid after edge N, for one cycle (rd_valid); data held thereafter.
- FWFT: write into empty FIFO at edge N -> rd_valid=1 and rd_dout=word after edge N (zero extra latency).
- Error pulses: 1 cycle, asserted after the edge at which the offending request was sampled.
- Back-to-back reads/writes sustain 1 word per cycle each, concurrently.
- Pointer wrap and count update are in the same cycle; no bubble at wrap.

## Test plan
- Reset then idle: after rst, empty=1, al_empty=1, full=0, count=0, rd_valid=0; rd_en=1 one cycle -> underflow=1 one cycle, count stays 0.
- Fill DEPTH=12 (non-power-of-two), AF_THR=10: write 0..11 -> al_full rises when count=10, full when count=12; 13th write -> overflow pulse, count 12; read all in standard mode -> rd_dout 0..11 in order, each one cycle after rd_en.
- Simultaneous rd/wr at full: count=12, wr_en=rd_en=1 with 0xA5 -> count stays 12, full stays 1, no overflow; 0xA5 emerges last after draining.
- Simultaneous rd/wr at empty: wr_en=rd_en=1 -> underflow pulse, count=1, empty=0 next cycle; word readable after.
- FWFT=1: write 0x3C into empty -> next cycle rd_valid=1, rd_dout=0x3C without rd_en; rd_en=1 -> rd_valid=0 after edge.
- Wrap + mid-operation reset: stream 40 words with random rd/wr, compare against scoreboard; assert rst with count=7 -> all flags/count at reset values next cycle, no stale data returned.
